// File: rtl/int_to_float_81.sv
// Multi-cycle 32-bit integer to IEEE-754 single-precision converter.
// One operand in flight: IDLE accepts, NORM shifts out leading zeros in 5 binary steps, ROUND packs, DONE presents.
module int_to_float_81 #(
  parameter bit SIGNED_81     = 1'b1,
  parameter bit ROUND_MODE_81 = 1'b0
) (
  input  logic        clk81,
  input  logic        reset_81,
  input  logic [31:0] a81,
  input  logic        in_valid_81,
  output logic        in_ready_81,
  output logic [31:0] result_81,
  output logic        out_valid_81,
  input  logic        out_ready_81,
  output logic [1:0]  state_dbg_81
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both 1;
  // result_81 and out_valid_81 stay stable until out_ready_81 takes the result.
  typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;

  state_t      state_q, state_d;
  logic [31:0] mag_q, mag_d;
  logic [4:0]  lz_q, lz_d;
  logic [2:0]  step_q, step_d;
  logic        sign_q, sign_d;
  logic        zero_q, zero_d;
  logic [31:0] result_q, result_d;

  logic [5:0]  shift_n;
  logic        top_zero;
  logic [22:0] mant;
  logic        guard;
  logic        sticky;
  logic        rnd_up;
  logic [23:0] mant_sum;
  logic [7:0]  exp_base;
  logic [7:0]  exp_fin;
  logic [22:0] mant_fin;

  always_comb begin
    shift_n = 6'd1 << step_q;
    case (step_q)
      3'd4:    top_zero = (mag_q[31:16] == 16'd0);
      3'd3:    top_zero = (mag_q[31:24] == 8'd0);
      3'd2:    top_zero = (mag_q[31:28] == 4'd0);
      3'd1:    top_zero = (mag_q[31:30] == 2'd0);
      3'd0:    top_zero = ~mag_q[31];
      default: top_zero = 1'b0;
    endcase
  end

  // After normalisation bit 31 is the hidden one; bits 30:8 form the mantissa.
  always_comb begin
    mant     = mag_q[30:8];
    guard    = mag_q[7];
    sticky   = |mag_q[6:0];
    rnd_up   = !ROUND_MODE_81 && guard && (sticky || mant[0]);
    mant_sum = {1'b0, mant} + {23'd0, rnd_up};
    exp_base = 8'd158 - {3'd0, lz_q};
    if (mant_sum[23]) begin
      mant_fin = 23'd0;
      exp_fin  = exp_base + 8'd1;
    end else begin
      mant_fin = mant_sum[22:0];
      exp_fin  = exp_base;
    end
  end

  always_comb begin
    state_d  = state_q;
    mag_d    = mag_q;
    lz_d     = lz_q;
    step_d   = step_q;
    sign_d   = sign_q;
    zero_d   = zero_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (in_valid_81) begin
          sign_d  = SIGNED_81 && a81[31];
          mag_d   = sign_d ? (~a81 + 32'd1) : a81;
          zero_d  = (a81 == 32'd0);
          lz_d    = 5'd0;
          step_d  = 3'd4;
          state_d = NORM;
        end
      end
      NORM: begin
        if (top_zero) begin
          mag_d = mag_q << shift_n;
          lz_d  = lz_q + shift_n[4:0];
        end
        if (step_q == 3'd0) begin
          state_d = ROUND;
        end else begin
          step_d = step_q - 3'd1;
        end
      end
      ROUND: begin
        result_d = zero_q ? 32'd0 : {sign_q, exp_fin, mant_fin};
        state_d  = DONE;
      end
      DONE: begin
        if (out_ready_81) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk81) begin
    if (reset_81) begin
      state_q  <= IDLE;
      mag_q    <= 32'd0;
      lz_q     <= 5'd0;
      step_q   <= 3'd0;
      sign_q   <= 1'b0;
      zero_q   <= 1'b0;
      result_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      mag_q    <= mag_d;
      lz_q     <= lz_d;
      step_q   <= step_d;
      sign_q   <= sign_d;
      zero_q   <= zero_d;
      result_q <= result_d;
    end
  end

  assign in_ready_81  = (state_q == IDLE);
  assign out_valid_81 = (state_q == DONE);
  assign result_81    = result_q;
  assign state_dbg_81 = state_q;

endmodule

// File: tb/tb_int_to_float_81.sv
// Bench for int_to_float_81: three instances (signed RNE, signed truncate, unsigned RNE) share one stimulus
// and are checked against an arithmetic reference model, with latency, backpressure and reset checks.
module tb_int_to_float_81;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] a_in;
  logic        in_valid;
  logic        out_ready;
  logic        in_ready_s, in_ready_t, in_ready_u;
  logic        out_valid_s, out_valid_t, out_valid_u;
  logic [31:0] res_s, res_t, res_u;
  logic [1:0]  st_s, st_t, st_u;

  int checks = 0;
  int errors = 0;
  logic [31:0] last_s, last_t, last_u;

  always #5 clk = ~clk;

  int_to_float_81 #(.SIGNED_81(1'b1), .ROUND_MODE_81(1'b0)) dut_s (
    .clk81(clk), .reset_81(reset), .a81(a_in), .in_valid_81(in_valid), .in_ready_81(in_ready_s),
    .result_81(res_s), .out_valid_81(out_valid_s), .out_ready_81(out_ready), .state_dbg_81(st_s));
  int_to_float_81 #(.SIGNED_81(1'b1), .ROUND_MODE_81(1'b1)) dut_t (
    .clk81(clk), .reset_81(reset), .a81(a_in), .in_valid_81(in_valid), .in_ready_81(in_ready_t),
    .result_81(res_t), .out_valid_81(out_valid_t), .out_ready_81(out_ready), .state_dbg_81(st_t));
  int_to_float_81 #(.SIGNED_81(1'b0), .ROUND_MODE_81(1'b0)) dut_u (
    .clk81(clk), .reset_81(reset), .a81(a_in), .in_valid_81(in_valid), .in_ready_81(in_ready_u),
    .result_81(res_u), .out_valid_81(out_valid_u), .out_ready_81(out_ready), .state_dbg_81(st_u));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: locate the top set bit, then round the dropped bits with plain integer arithmetic.
  function automatic logic [31:0] ref_conv(input logic [31:0] a, input bit sgn, input bit trunc);
    longint unsigned mag, q, rem, half;
    bit s;
    int p, e, sh;
    s   = sgn && a[31];
    mag = s ? ((64'd1 << 32) - {32'd0, a}) : {32'd0, a};
    if (mag == 0) return 32'd0;
    p = 31;
    while (((mag >> p) & 64'd1) == 0) p--;
    e = 127 + p;
    if (p <= 23) begin
      q = mag << (23 - p);
    end else begin
      sh   = p - 23;
      q    = mag >> sh;
      rem  = mag & ((64'd1 << sh) - 64'd1);
      half = 64'd1 << (sh - 1);
      if (!trunc && (rem > half || (rem == half && q[0]))) q++;
      if (q == (64'd1 << 24)) begin
        q = q >> 1;
        e++;
      end
    end
    return {s, e[7:0], q[22:0]};
  endfunction

  task automatic run_conv(input logic [31:0] a, input bit hold);
    logic [31:0] e_s, e_t, e_u;
    int k;
    e_s = ref_conv(a, 1'b1, 1'b0);
    e_t = ref_conv(a, 1'b1, 1'b1);
    e_u = ref_conv(a, 1'b0, 1'b0);
    out_ready = !hold;
    check("in_ready_idle", {31'd0, in_ready_s & in_ready_t & in_ready_u}, 32'd1);
    a_in = a;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a_in = $urandom;
    k = 0;
    while (!(out_valid_s && out_valid_t && out_valid_u) && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    check("latency", k, 32'd6);
    check("res_signed_rne", res_s, e_s);
    check("res_signed_trunc", res_t, e_t);
    check("res_unsigned_rne", res_u, e_u);
    last_s = res_s;
    last_t = res_t;
    last_u = res_u;
    if (hold) begin
      for (int i = 0; i < 3; i++) begin
        in_valid = 1'b1;
        a_in = $urandom;
        @(posedge clk); #1;
        check("hold_result", res_s, e_s);
        check("hold_valid", {31'd0, out_valid_s}, 32'd1);
        check("hold_in_ready", {31'd0, in_ready_s}, 32'd0);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
    end
    @(posedge clk); #1;
    check("handoff_valid", {31'd0, out_valid_s | out_valid_t | out_valid_u}, 32'd0);
    check("handoff_idle", {31'd0, in_ready_s & in_ready_t & in_ready_u}, 32'd1);
  endtask

  initial begin
    logic [31:0] r;
    bit seen;
    reset = 1'b1;
    a_in = 32'd0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check("reset_result", res_s, 32'd0);
    check("reset_valid", {31'd0, out_valid_s}, 32'd0);
    check("reset_in_ready", {31'd0, in_ready_s}, 32'd1);

    run_conv(32'd1, 1'b0);
    check("tp_one", last_s, 32'h3F800000);
    run_conv(32'hFFFFFFFF, 1'b0);
    check("tp_minus_one", last_s, 32'hBF800000);
    check("tp_unsigned_max", last_u, 32'h4F800000);
    run_conv(32'd0, 1'b0);
    check("tp_zero", last_s, 32'h00000000);
    run_conv(32'h80000000, 1'b0);
    check("tp_int_min", last_s, 32'hCF000000);
    check("tp_unsigned_msb", last_u, 32'h4F000000);
    run_conv(32'd16777217, 1'b0);
    check("tp_tie_even", last_s, 32'h4B800000);
    run_conv(32'd16777219, 1'b0);
    check("tp_tie_up", last_s, 32'h4B800002);
    check("tp_trunc_tie", last_t, 32'h4B800001);
    run_conv(32'h7FFFFFFF, 1'b0);
    check("tp_carry", last_s, 32'h4F000000);
    check("tp_trunc_max", last_t, 32'h4EFFFFFF);

    run_conv(32'd12345, 1'b1);

    // Reset sampled on the edge that would perform NORM step 2.
    a_in = 32'h00ABCDEF;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("midreset_valid", {31'd0, out_valid_s}, 32'd0);
    check("midreset_in_ready", {31'd0, in_ready_s}, 32'd1);
    seen = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      if (out_valid_s || out_valid_t || out_valid_u) seen = 1'b1;
    end
    check("abandoned_no_result", {31'd0, seen}, 32'd0);
    run_conv(32'hFFFF0001, 1'b0);

    for (int n = 0; n < 40; n++) begin
      r = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 1) r = ~r + 32'd1;
      run_conv(r, ($urandom_range(0, 7) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
